// File: rtl/ram_writer_sync_pkg.sv
// Shared definitions for the RAM writer block.
// FSM encodings and default geometry.
package ram_writer_defs;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/ram_writer_sync_ram.sv
// One-write, one-read synchronous RAM with registered read-first port.
// Whole array clears to zero on reset.
module sync_ram_1r1w #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read samples the pre-edge array, so a same-address write reads old data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/ram_writer_sync.sv
// RAM writer: single-word handshake writes or an incrementing burst fill.
// Status outputs decode from registered state only.
module ram_writer_sync
   import ram_writer_defs::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              fill_start,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              fill_done,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] seed;

   logic              in_fill;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign wr_ready  = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign fill_done = (state == ST_DONE);
   assign in_fill   = (state == ST_FILL);

   // Fill owns the write port; handshake writes only land in IDLE.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
      if (in_fill) begin
         ram_we    = 1'b1;
         ram_waddr = idx;
         ram_wdata = seed + DATA_W'(idx);
      end else if (wr_valid && wr_ready) begin
         ram_we = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         seed  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fill_start) begin
                  state <= ST_FILL;
                  seed  <= fill_data;
                  idx   <= '0;
               end
            end
            ST_FILL: begin
               idx <= idx + 1'b1;
               if (idx == LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   sync_ram_1r1w #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr(rd_addr),
      .rdata(rd_data)
   );

endmodule

// File: tb/tb_ram_writer_sync.sv
// Directed vector bench for ram_writer_sync (DATA_W=4, ADDR_W=2).
// Each vector is one clock edge; outputs are compared at the next falling edge.
module tb_ram_writer_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_addr;
   logic [3:0] wr_data;
   logic       fill_start;
   logic [3:0] fill_data;
   logic       busy;
   logic       fill_done;
   logic [1:0] rd_addr;
   logic [3:0] rd_data;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   logic watch = 1'b0;

   typedef struct {
      logic       wv;
      logic [1:0] wa;
      logic [3:0] wd;
      logic       fs;
      logic [3:0] fd;
      logic [1:0] ra;
      logic       rdy;
      logic       bsy;
      logic       dn;
      logic [3:0] rd;
   } vec_t;

   vec_t tv[$];

   ram_writer_sync #(.DATA_W(4), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .fill_start(fill_start),
      .fill_data (fill_data),
      .busy      (busy),
      .fill_done (fill_done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (watch && fill_done) done_seen++;
   end

   function automatic vec_t mk(
      logic wv, logic [1:0] wa, logic [3:0] wd,
      logic fs, logic [3:0] fd, logic [1:0] ra,
      logic rdy, logic bsy, logic dn, logic [3:0] rd);
      vec_t v;
      v.wv = wv; v.wa = wa; v.wd = wd;
      v.fs = fs; v.fd = fd; v.ra = ra;
      v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.rd = rd;
      return v;
   endfunction

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      wr_valid = 0; wr_addr = 0; wr_data = 0;
      fill_start = 0; fill_data = 0;
   endtask

   initial begin
      rst_n = 0;
      rd_addr = 0;
      idle_inputs();
      #1;
      chk("rst_ready", 4'(wr_ready), 4'h1);
      chk("rst_busy", 4'(busy), 4'h0);
      chk("rst_done", 4'(fill_done), 4'h0);
      chk("rst_rd", rd_data, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      // single writes, read-back
      tv.push_back(mk(1, 0, 4'hE, 0, 0, 0, 1, 0, 0, 4'h0));
      tv.push_back(mk(1, 1, 4'h2, 0, 0, 0, 1, 0, 0, 4'hE));
      tv.push_back(mk(1, 2, 4'hF, 0, 0, 1, 1, 0, 0, 4'h2));
      tv.push_back(mk(1, 3, 4'h4, 0, 0, 2, 1, 0, 0, 4'hF));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 3, 1, 0, 0, 4'h4));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'hE));
      // fill seed E with wrap, writes ignored during fill
      tv.push_back(mk(0, 0, 4'h0, 1, 4'hE, 0, 0, 1, 0, 4'hE));
      tv.push_back(mk(1, 0, 4'h7, 0, 0, 0, 0, 1, 0, 4'hE));
      tv.push_back(mk(1, 1, 4'h7, 0, 0, 1, 0, 1, 0, 4'h2));
      tv.push_back(mk(1, 2, 4'h7, 0, 0, 0, 0, 1, 0, 4'hE));
      tv.push_back(mk(1, 3, 4'h7, 0, 0, 2, 0, 1, 1, 4'h0));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 3, 1, 0, 0, 4'h1));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 4'hF));
      // read-during-write returns old data
      tv.push_back(mk(1, 2, 4'h5, 0, 0, 0, 1, 0, 0, 4'hE));
      tv.push_back(mk(1, 2, 4'h9, 0, 0, 2, 1, 0, 0, 4'h5));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 2, 1, 0, 0, 4'h9));
      // write and fill_start on the same edge
      tv.push_back(mk(1, 1, 4'hA, 1, 4'h0, 1, 0, 1, 0, 4'hF));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 4'hA));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 1, 0, 1, 0, 4'hA));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 2, 0, 1, 0, 4'h9));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 1, 1, 4'h0));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 1, 1, 0, 0, 4'h1));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 2, 1, 0, 0, 4'h2));
      tv.push_back(mk(0, 0, 4'h0, 0, 0, 3, 1, 0, 0, 4'h3));

      @(negedge clk);
      for (int i = 0; i < tv.size(); i++) begin
         wr_valid = tv[i].wv;
         wr_addr = tv[i].wa;
         wr_data = tv[i].wd;
         fill_start = tv[i].fs;
         fill_data = tv[i].fd;
         rd_addr = tv[i].ra;
         step();
         chk($sformatf("v%0d_ready", i), 4'(wr_ready), 4'(tv[i].rdy));
         chk($sformatf("v%0d_busy", i), 4'(busy), 4'(tv[i].bsy));
         chk($sformatf("v%0d_done", i), 4'(fill_done), 4'(tv[i].dn));
         chk($sformatf("v%0d_rd", i), rd_data, tv[i].rd);
      end

      // reset in the middle of a fill (seed 3)
      idle_inputs();
      rd_addr = 0;
      fill_start = 1;
      fill_data = 4'h3;
      watch = 1;
      step();
      fill_start = 0;
      step();
      step();
      chk("mid_busy", 4'(busy), 4'h1);
      rst_n = 0;
      #1;
      chk("mid_rst_busy", 4'(busy), 4'h0);
      chk("mid_rst_done", 4'(fill_done), 4'h0);
      chk("mid_rst_ready", 4'(wr_ready), 4'h1);
      chk("mid_rst_rd", rd_data, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int a = 0; a < 4; a++) begin
         rd_addr = 2'(a);
         step();
         chk($sformatf("clr_rd%0d", a), rd_data, 4'h0);
         chk($sformatf("clr_busy%0d", a), 4'(busy), 4'h0);
      end
      step();
      step();
      watch = 0;
      chk("no_done_pulse", 4'(done_seen), 4'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
